// File: rtl/sc1602_seq_ctrl_if.sv
// Request handshake and LCD pin bundle for the SC1602 4-bit sequencer.
// The slave modport is the sequencer side.
interface sc1602_seq_ctrl_if;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [3:0] lcd_d;

  modport slave (
    input  req_valid, req_rs, req_data,
    output req_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_d
  );

  modport master (
    output req_valid, req_rs, req_data,
    input  req_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_d
  );
endinterface

// File: rtl/sc1602_seq_ctrl.sv
// HD44780 4-bit write sequencer: self-running power-up/init, then byte writes
// split into two strobed nibbles followed by the command execution wait.
module sc1602_seq_ctrl #(
  parameter logic [23:0] T_PWRUP = 24'd405_000,
  parameter logic [23:0] T_INIT  = 24'd110_700,
  parameter logic [23:0] T_EN    = 24'd13,
  parameter logic [23:0] T_CMD   = 24'd1_188,
  parameter logic [23:0] T_CLR   = 24'd44_280
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  sc1602_seq_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, GAP, WAIT, IDLE} state_t;

  state_t      state, state_nxt;
  logic [23:0] cnt, len, wait_len;
  logic [2:0]  step, step_sel;
  logic [7:0]  byte_q;
  logic        rs_q, single_q, lo_q, in_init;
  logic        ld_init, ld_req, set_lo, end_init, accept, done;
  logic [3:0]  nib;
  logic [8:0]  entry;
  logic        en_q, rs_out, ready_q, done_q;
  logic [3:0]  d_q;

  // {single_nibble, byte} for each init step
  function automatic logic [8:0] init_entry(input logic [2:0] s);
    case (s)
      3'd0, 3'd1, 3'd2: init_entry = {1'b1, 8'h30};
      3'd3:             init_entry = {1'b1, 8'h20};
      3'd4:             init_entry = {1'b0, 8'h28};
      3'd5:             init_entry = {1'b0, 8'h0C};
      3'd6:             init_entry = {1'b0, 8'h01};
      default:          init_entry = {1'b0, 8'h06};
    endcase
  endfunction

  always_comb begin
    nib      = lo_q ? byte_q[3:0] : byte_q[7:4];
    step_sel = (state == PWRUP) ? 3'd0 : step + 3'd1;
    entry    = init_entry(step_sel);
    if (single_q)                             wait_len = (step < 3'd2) ? T_INIT : T_CMD;
    else if (!rs_q && byte_q[7:2] == 6'd0)    wait_len = T_CLR;
    else                                      wait_len = T_CMD;
    case (state)
      PWRUP:      len = T_PWRUP;
      PULSE, GAP: len = T_EN;
      WAIT:       len = wait_len;
      default:    len = 24'd1;
    endcase
    done   = (cnt == len - 24'd1);
    accept = (state == IDLE) && bus.req_valid && ready_q;
  end

  always_comb begin
    state_nxt = state;
    ld_init   = 1'b0;
    ld_req    = 1'b0;
    set_lo    = 1'b0;
    end_init  = 1'b0;
    case (state)
      PWRUP: if (done) begin state_nxt = SETUP; ld_init = 1'b1; end
      SETUP: state_nxt = PULSE;
      PULSE: if (done) state_nxt = HOLD;
      HOLD:  state_nxt = (single_q || lo_q) ? WAIT : GAP;
      GAP:   if (done) begin state_nxt = SETUP; set_lo = 1'b1; end
      WAIT:  if (done) begin
               if (in_init && step != 3'd7) begin
                 state_nxt = SETUP;
                 ld_init   = 1'b1;
               end else begin
                 state_nxt = IDLE;
                 end_init  = in_init;
               end
             end
      IDLE:  if (accept) begin state_nxt = SETUP; ld_req = 1'b1; end
      default: state_nxt = PWRUP;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= PWRUP;
      cnt      <= 24'd0;
      step     <= 3'd0;
      byte_q   <= 8'h00;
      rs_q     <= 1'b0;
      single_q <= 1'b0;
      lo_q     <= 1'b0;
      in_init  <= 1'b1;
    end else begin
      state <= state_nxt;
      // counter restarts on every state change and idles in IDLE, so it never wraps
      if (state_nxt != state)  cnt <= 24'd0;
      else if (state != IDLE)  cnt <= cnt + 24'd1;
      if (ld_init) begin
        step               <= step_sel;
        {single_q, byte_q} <= entry;
        rs_q               <= 1'b0;
        lo_q               <= 1'b0;
      end
      if (ld_req) begin
        byte_q   <= bus.req_data;
        rs_q     <= bus.req_rs;
        single_q <= 1'b0;
        lo_q     <= 1'b0;
      end
      if (set_lo)   lo_q    <= 1'b1;
      if (end_init) in_init <= 1'b0;
    end
  end

  // Pins follow the state register by one cycle; ready drops on the accept edge itself.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_q    <= 1'b0;
      rs_out  <= 1'b0;
      d_q     <= 4'h0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q <= (state == PULSE);
      if (state == SETUP) begin
        d_q    <= nib;
        rs_out <= rs_q;
      end
      ready_q <= (state == IDLE) && !accept;
      done_q  <= done_q | (state == IDLE);
    end
  end

  assign bus.lcd_en    = en_q;
  assign bus.lcd_rs    = rs_out;
  assign bus.lcd_d     = d_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.req_ready = ready_q;
  assign bus.init_done = done_q;

endmodule
